// File: rtl/bus_pipe_reg.sv
// Elastic WIDTH x DEPTH register pipeline: valid/ready handshake, bubble collapsing,
// synchronous flush and occupancy count. Define BUS_PIPE_PARITY_EN to add per-word parity.
module bus_pipe_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
`ifdef BUS_PIPE_PARITY_EN
  input  logic             IN_PAR,
  output logic             OUT_PAR,
  output logic             PAR_ERR,
`endif
  output logic [CNTW-1:0]  COUNT
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CNTW-1:0]  r_count;
  logic [DEPTH-1:0] w_mv;
  logic             w_accept;
  logic             w_out_xfer;

  // Move chain resolved from the output side so a full pipe can shift in lockstep
  always_comb begin
    w_mv          = '0;
    w_mv[DEPTH-1] = r_v[DEPTH-1] & OUT_READY;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      w_mv[i] = r_v[i] & (~r_v[i+1] | w_mv[i+1]);
    end
  end

  assign IN_READY   = ~FLUSH & (~r_v[0] | w_mv[0]);
  assign w_accept   = IN_VALID & IN_READY;
  assign OUT_VALID  = r_v[DEPTH-1] & ~FLUSH;
  assign w_out_xfer = OUT_VALID & OUT_READY;
  assign OUT_DATA   = r_d[DEPTH-1];
  assign COUNT      = r_count;

  // Stage valid/data registers; data only ever loads real words
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_v <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_d[i] <= '0;
      end
    end else if (FLUSH) begin
      r_v <= '0;
    end else begin
      if (w_accept) begin
        r_d[0] <= IN_DATA;
        r_v[0] <= 1'b1;
      end else if (w_mv[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_mv[i-1]) begin
          r_d[i] <= r_d[i-1];
          r_v[i] <= 1'b1;
        end else if (w_mv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy tracks accepts minus output transfers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_count <= '0;
    end else if (FLUSH) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_out_xfer})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BUS_PIPE_PARITY_EN
  logic [DEPTH-1:0] r_p;
  logic             r_par_err;

  // Parity bit travels with its word; error flag is sticky until reset
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_p       <= '0;
      r_par_err <= 1'b0;
    end else if (!FLUSH) begin
      if (w_accept) begin
        r_p[0] <= IN_PAR;
        if ((^IN_DATA) != IN_PAR) begin
          r_par_err <= 1'b1;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_mv[i-1]) begin
          r_p[i] <= r_p[i-1];
        end
      end
    end
  end

  assign OUT_PAR = r_p[DEPTH-1];
  assign PAR_ERR = r_par_err;
`endif

endmodule

// File: tb/tb_bus_pipe_reg.sv
// Directed bench for bus_pipe_reg (DEPTH=4 main instance, DEPTH=1 degenerate instance).
module tb_bus_pipe_reg;

  logic       clk;
  logic       rn;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       v1;
  logic       rdy1;
  logic [7:0] d1;
  logic       ov1;
  logic       ordy1;
  logic [7:0] od1;
  logic       cnt1;

  int n_chk;
  int n_bad;

`ifdef BUS_PIPE_PARITY_EN
  logic par_bad;
  logic in_par;
  logic out_par;
  logic par_err;
  logic in_par1;
  logic out_par1;
  logic par_err1;
  assign in_par  = (^in_data) ^ par_bad;
  assign in_par1 = ^d1;
`endif

  bus_pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut (
    .CLK       (clk),
    .RN        (rn),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
`ifdef BUS_PIPE_PARITY_EN
    .IN_PAR    (in_par),
    .OUT_PAR   (out_par),
    .PAR_ERR   (par_err),
`endif
    .COUNT     (count)
  );

  bus_pipe_reg #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .CLK       (clk),
    .RN        (rn),
    .FLUSH     (1'b0),
    .IN_VALID  (v1),
    .IN_READY  (rdy1),
    .IN_DATA   (d1),
    .OUT_VALID (ov1),
    .OUT_READY (ordy1),
    .OUT_DATA  (od1),
`ifdef BUS_PIPE_PARITY_EN
    .IN_PAR    (in_par1),
    .OUT_PAR   (out_par1),
    .PAR_ERR   (par_err1),
`endif
    .COUNT     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    v1 = 1'b0; d1 = 8'h00; ordy1 = 1'b0;
`ifdef BUS_PIPE_PARITY_EN
    par_bad = 1'b0;
`endif

    // Reset state
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    tick(); tick();
    rn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Streaming 0x01..0x10 with OUT_READY high
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      if (c < 16) chk("stream_in_ready", 32'(in_ready), 1);
      tick();
      chk("stream_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) chk("stream_out_data", 32'(out_data), 32'(c - 2));
      if (c <= 15) chk("stream_count", 32'(count), (c + 1 < 4) ? 32'(c + 1) : 4);
    end
    chk("stream_drained", 32'(count), 0);

    // Back-pressure until full, then simultaneous in/out
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'hA0 + j);
      #1;
      chk("bp_in_ready", 32'(in_ready), 1);
      tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_data", 32'(out_data), 'hA0);
    in_data = 8'hA4;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    tick();
    chk("full_hold_count", 32'(count), 4);
    in_data = 8'hA5;
    #1;
    chk("full_in_ready2", 32'(in_ready), 0);
    in_data   = 8'hA4;
    out_ready = 1'b1;
    #1;
    chk("full_release_in_ready", 32'(in_ready), 1);
    tick();
    chk("full_swap_count", 32'(count), 4);
    chk("full_swap_out_data", 32'(out_data), 'hA1);
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("bp_drain_data", 32'(out_data), 32'(32'hA2 + j));
      chk("bp_drain_count", 32'(count), 32'(3 - j));
    end
    tick();
    chk("bp_empty_valid", 32'(out_valid), 0);
    chk("bp_empty_count", 32'(count), 0);

    // Bubble collapse while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("bub_count", 32'(count), 2);
    chk("bub_out_valid", 32'(out_valid), 1);
    chk("bub_out_data", 32'(out_data), 'h11);
    chk("bub_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("bub_next_valid", 32'(out_valid), 1);
    chk("bub_next_data", 32'(out_data), 'h22);
    tick();
    chk("bub_empty_valid", 32'(out_valid), 0);
    chk("bub_empty_count", 32'(count), 0);

    // Flush with three words held
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h31 + j);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("fl_pre_count", 32'(count), 3);
    chk("fl_pre_data", 32'(out_data), 'h31);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fl_count", 32'(count), 0);
    chk("fl_post_valid", 32'(out_valid), 0);
    chk("fl_stale_data", 32'(out_data), 'h31);
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("fl_resume_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("fl_resume_count", 32'(count), 1);
    tick(); tick(); tick();
    chk("fl_resume_valid", 32'(out_valid), 1);
    chk("fl_resume_data", 32'(out_data), 'h55);
    out_ready = 1'b1;
    tick();
    chk("fl_resume_empty", 32'(count), 0);

`ifdef BUS_PIPE_PARITY_EN
    // Parity error capture and delivery
    out_ready = 1'b0;
    chk("par_clean", 32'(par_err), 0);
    par_bad = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    tick();
    in_valid = 1'b0; par_bad = 1'b0;
    chk("par_err_set", 32'(par_err), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("par_err_sticky", 32'(par_err), 1);
    in_valid = 1'b1; in_data = 8'h07;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("par_out_valid", 32'(out_valid), 1);
    chk("par_out_data", 32'(out_data), 'h07);
    chk("par_out_par", 32'(out_par), 1);
    tick();
`endif

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h61 + j);
      tick();
    end
    in_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 3);
    rn = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_data", 32'(out_data), 0);
`ifdef BUS_PIPE_PARITY_EN
    chk("ar_par_err", 32'(par_err), 0);
`endif
    #1;
    rn = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 8'h71;
    tick();
    in_valid = 1'b0;
    chk("ar_first_accept", 32'(count), 1);

    // DEPTH=1 degenerate register
    ordy1 = 1'b0; v1 = 1'b1; d1 = 8'h5A;
    #1;
    chk("d1_ready_empty", 32'(rdy1), 1);
    tick();
    chk("d1_out_valid", 32'(ov1), 1);
    chk("d1_out_data", 32'(od1), 'h5A);
    chk("d1_count", 32'(cnt1), 1);
    d1 = 8'h5B;
    #1;
    chk("d1_ready_full", 32'(rdy1), 0);
    ordy1 = 1'b1;
    #1;
    chk("d1_ready_pass", 32'(rdy1), 1);
    tick();
    chk("d1_swap_data", 32'(od1), 'h5B);
    chk("d1_swap_count", 32'(cnt1), 1);
    v1 = 1'b0;
    tick();
    chk("d1_empty_valid", 32'(ov1), 0);
    chk("d1_empty_count", 32'(cnt1), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
